// File: rtl/brent_kung_subtractor_pipe_32b_pkg.sv
// Shared definitions for the 32-bit pipelined Brent-Kung subtractor.
//   DATA_W     : full operand / result width
//   SLICE_W    : width handled by one pipeline stage
//   NUM_STAGES : number of pipeline stages (DATA_W / SLICE_W)
//   stage_t    : one pipeline stage register (valid, carry, skewed operands,
//                partially assembled result, operand sign bits)
//   sub_overflow : signed overflow rule for a - b
package brent_kung_subtractor_pipe_32b_pkg;

    localparam int DATA_W     = 32;
    localparam int SLICE_W    = 8;
    localparam int NUM_STAGES = 4;

    typedef struct packed {
        logic              valid;
        logic              carry;   // carry into the next slice (inverted borrow)
        logic [DATA_W-1:0] opa;     // minuend, bytes above this stage still pending
        logic [DATA_W-1:0] opb;     // subtrahend, bytes above this stage still pending
        logic [DATA_W-1:0] res;     // result bytes produced so far
        logic              sign_a;
        logic              sign_b;
    } stage_t;

    // Overflow of a - b: operands of opposite sign and the result sign
    // differs from the minuend sign.
    function automatic logic sub_overflow(input logic sign_a,
                                          input logic sign_b,
                                          input logic sign_d);
        return (sign_a != sign_b) && (sign_d != sign_a);
    endfunction

endpackage

// File: rtl/brent_kung_adder_8b.sv
// 8-bit Brent-Kung parallel-prefix adder slice.
//   a, b  : addends
//   cin   : carry in
//   sum   : a + b + cin (low 8 bits)
//   cout  : carry out
// The carry-in is folded into bit 0's generate, so every prefix span that
// starts at bit 0 needs only a group generate.
module brent_kung_adder_8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic       g0c;
    logic       g1_0, g3_2, g5_4, g7_6;
    logic       p3_2, p5_4, p7_6;
    logic       g3_0, g7_4, p7_4;
    logic       g7_0;
    logic       g2_0, g4_0, g5_0, g6_0;
    logic [7:0] c;

    assign g   = a & b;
    assign p   = a ^ b;
    assign g0c = g[0] | (p[0] & cin);

    // Up-sweep: pairs, then nibbles, then the full byte.
    assign g1_0 = g[1] | (p[1] & g0c);
    assign g3_2 = g[3] | (p[3] & g[2]);
    assign p3_2 = p[3] & p[2];
    assign g5_4 = g[5] | (p[5] & g[4]);
    assign p5_4 = p[5] & p[4];
    assign g7_6 = g[7] | (p[7] & g[6]);
    assign p7_6 = p[7] & p[6];

    assign g3_0 = g3_2 | (p3_2 & g1_0);
    assign g7_4 = g7_6 | (p7_6 & g5_4);
    assign p7_4 = p7_6 & p5_4;

    assign g7_0 = g7_4 | (p7_4 & g3_0);

    // Down-sweep fills in the remaining prefixes.
    assign g5_0 = g5_4 | (p5_4 & g3_0);
    assign g2_0 = g[2] | (p[2] & g1_0);
    assign g4_0 = g[4] | (p[4] & g3_0);
    assign g6_0 = g[6] | (p[6] & g5_0);

    assign c    = {g6_0, g5_0, g4_0, g3_0, g2_0, g1_0, g0c, cin};
    assign sum  = p ^ c;
    assign cout = g7_0;

endmodule

// File: rtl/brent_kung_subtractor_pipe_32b.sv
// 32-bit subtractor built from four 8-bit Brent-Kung slices, one per
// pipeline stage, with valid/ready flow control.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   valid_i / ready_o    : operand handshake
//   op1_i, op2_i         : minuend, subtrahend
//   borrow_i             : borrow in
//   valid_o / ready_i    : result handshake
//   diff_o               : op1 - op2 - borrow (mod 2^32)
//   borrow_o             : unsigned borrow out
//   overflow_o           : signed overflow
//   zero_o               : diff_o == 0
// Subtraction is op1 + ~op2 + ~borrow_i; the final carry is the inverted
// borrow. Outputs are forced to zero whenever valid_o is low, so diff_o is
// quiet during bubbles and reset.
module brent_kung_subtractor_pipe_32b
    import brent_kung_subtractor_pipe_32b_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic              borrow_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] diff_o,
    output logic              borrow_o,
    output logic              overflow_o,
    output logic              zero_o
);

    stage_t stg_p0, stg_p1, stg_p2, stg_p3;
    stage_t nxt_p0, nxt_p1, nxt_p2, nxt_p3;
    logic   adv;

    logic [SLICE_W-1:0] sl_a   [NUM_STAGES];
    logic [SLICE_W-1:0] sl_b   [NUM_STAGES];
    logic [SLICE_W-1:0] sl_sum [NUM_STAGES];
    logic               sl_cin [NUM_STAGES];
    logic               sl_cout[NUM_STAGES];

    // The whole pipeline moves as one; it stalls only when a result is
    // waiting and the consumer is not taking it.
    assign adv     = ~stg_p3.valid | ready_i;
    assign ready_o = adv;

    // Slice operand selection: stage k consumes byte k of the skewed operands.
    assign sl_a[0]   = op1_i[SLICE_W-1:0];
    assign sl_b[0]   = ~op2_i[SLICE_W-1:0];
    assign sl_cin[0] = ~borrow_i;

    assign sl_a[1]   = stg_p0.opa[2*SLICE_W-1:SLICE_W];
    assign sl_b[1]   = ~stg_p0.opb[2*SLICE_W-1:SLICE_W];
    assign sl_cin[1] = stg_p0.carry;

    assign sl_a[2]   = stg_p1.opa[3*SLICE_W-1:2*SLICE_W];
    assign sl_b[2]   = ~stg_p1.opb[3*SLICE_W-1:2*SLICE_W];
    assign sl_cin[2] = stg_p1.carry;

    assign sl_a[3]   = stg_p2.opa[4*SLICE_W-1:3*SLICE_W];
    assign sl_b[3]   = ~stg_p2.opb[4*SLICE_W-1:3*SLICE_W];
    assign sl_cin[3] = stg_p2.carry;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
        brent_kung_adder_8b u_slice (
            .a    (sl_a[k]),
            .b    (sl_b[k]),
            .cin  (sl_cin[k]),
            .sum  (sl_sum[k]),
            .cout (sl_cout[k])
        );
    end

    // Stage 0 boundary: capture inputs and byte 0 of the difference.
    always_comb begin
        nxt_p0        = '0;
        nxt_p0.valid  = valid_i;
        nxt_p0.carry  = sl_cout[0];
        nxt_p0.opa    = op1_i;
        nxt_p0.opb    = op2_i;
        nxt_p0.res    = {{(DATA_W-SLICE_W){1'b0}}, sl_sum[0]};
        nxt_p0.sign_a = op1_i[DATA_W-1];
        nxt_p0.sign_b = op2_i[DATA_W-1];
    end

    // Stage 1 boundary: add byte 1, earlier result bytes ride along.
    always_comb begin
        nxt_p1                       = stg_p0;
        nxt_p1.carry                 = sl_cout[1];
        nxt_p1.res[2*SLICE_W-1:SLICE_W] = sl_sum[1];
    end

    // Stage 2 boundary: add byte 2.
    always_comb begin
        nxt_p2                           = stg_p1;
        nxt_p2.carry                     = sl_cout[2];
        nxt_p2.res[3*SLICE_W-1:2*SLICE_W] = sl_sum[2];
    end

    // Stage 3 boundary: add byte 3; the full result is now assembled.
    always_comb begin
        nxt_p3                           = stg_p2;
        nxt_p3.carry                     = sl_cout[3];
        nxt_p3.res[4*SLICE_W-1:3*SLICE_W] = sl_sum[3];
    end

    // Only the valid bits are reset; data contents of invalid stages are
    // don't-care and masked at the outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_p0.valid <= 1'b0;
            stg_p1.valid <= 1'b0;
            stg_p2.valid <= 1'b0;
            stg_p3.valid <= 1'b0;
        end else if (adv) begin
            stg_p0 <= nxt_p0;
            stg_p1 <= nxt_p1;
            stg_p2 <= nxt_p2;
            stg_p3 <= nxt_p3;
        end
    end

    // Operand bytes are fully consumed by the last stage.
    logic unused_p3_ops;
    assign unused_p3_ops = ^{stg_p3.opa, stg_p3.opb};

    assign valid_o    = stg_p3.valid;
    assign diff_o     = stg_p3.valid ? stg_p3.res : '0;
    assign borrow_o   = stg_p3.valid & ~stg_p3.carry;
    assign overflow_o = stg_p3.valid &
                        sub_overflow(stg_p3.sign_a, stg_p3.sign_b, stg_p3.res[DATA_W-1]);
    assign zero_o     = stg_p3.valid & (diff_o == '0);

endmodule

// File: doc/brent_kung_subtractor_pipe_32b.md
BRENT_KUNG_SUBTRACTOR_PIPE_32B -- requirements
Module: brent_kung_subtractor_pipe_32b

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 valid_i  input  1  the operand set on op1_i/op2_i/borrow_i is valid this cycle.
REQ-005 ready_o  output  1  the block accepts the operand set this cycle.
REQ-006 op1_i  input  32  minuend.
REQ-007 op2_i  input  32  subtrahend.
REQ-008 borrow_i  input  1  borrow-in, subtracted from the difference.
REQ-009 valid_o  output  1  diff_o and the flags are valid.
REQ-010 ready_i  input  1  the downstream consumer accepts the result this cycle.
REQ-011 diff_o  output  32  (op1_i - op2_i - borrow_i) mod 2^32.
REQ-012 borrow_o  output  1  high when op1_i < op2_i + borrow_i (unsigned).
REQ-013 overflow_o  output  1  signed two's-complement overflow of the subtraction.
REQ-014 zero_o  output  1  high when diff_o == 0.

Function
REQ-015 The difference SHALL be computed as op1 + ~op2 + ~borrow_i; borrow_o SHALL equal the inverted final carry.
REQ-016 The pipeline SHALL have 4 stages; stage k SHALL compute diff bits [8k+7:8k] using an 8-bit Brent-Kung slice, with carry-in equal to ~borrow_i for k=0 and the registered carry-out of stage k-1 otherwise.
REQ-017 Operand bytes not yet consumed SHALL be carried forward in skew registers; result bytes already produced SHALL be carried forward in deskew registers, so all 32 result bits leave together.
REQ-018 Latency SHALL be exactly 4 cycles from an accepted input (valid_i & ready_o) to valid_o when ready_i is held high.
REQ-019 Throughput SHALL be one result per cycle when ready_i is held high.
REQ-020 Advance condition: adv = ~valid_o | ready_i; ready_o SHALL equal adv.
REQ-021 When adv is low, every stage register (data, carry, valid) SHALL hold its value and the outputs SHALL remain stable.
REQ-022 When adv is high, every stage valid bit SHALL shift forward, and stage 0 valid SHALL load valid_i.
REQ-023 Bubbles (valid_i low while adv is high) SHALL propagate as invalid stages; data registers of invalid stages are don't-care, but diff_o SHALL NOT change while valid_o is low.
REQ-024 overflow_o SHALL equal (op1[31] != op2[31]) & (diff[31] != op1[31]), using the op1/op2 sign bits carried to the last stage.
REQ-025 zero_o SHALL be derived from the final registered diff_o in the same cycle.
REQ-026 A result held under backpressure SHALL be presented unchanged until the cycle in which ready_i is high.

Reset
REQ-027 On rst_ni low, all stage valid bits SHALL clear immediately (asynchronously).
REQ-028 During reset, valid_o, diff_o, borrow_o, overflow_o and zero_o SHALL all be 0, and ready_o SHALL be 1 once reset is released.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results; no valid_o pulse SHALL occur for operands accepted before reset.
REQ-030 The first input SHALL be accepted in the first clock edge after rst_ni deasserts.

Structure
REQ-031 The shared package SHALL hold the constants DATA_W=32, SLICE_W=8 and NUM_STAGES=4, plus the stage-register struct type (valid, carry, skewed operands, partial result, sign bits).
REQ-032 The 8-bit slice SHALL be the existing brent_kung_adder_8b, instantiated once per stage (4 instances).
REQ-033 The block SHALL contain no other sub-modules; stage registers SHALL be inferred in a single clocked process.

Verification
REQ-034 Single transaction: op1=0x0000_0005, op2=0x0000_0003, borrow_i=0 -> after 4 cycles, diff=0x0000_0002, borrow_o=0, overflow_o=0, zero_o=0.
REQ-035 Wrap and borrow: op1=0, op2=1, borrow_i=0 -> diff=0xFFFF_FFFF, borrow_o=1; op1=0x10, op2=0x0F, borrow_i=1 -> diff=0, zero_o=1, borrow_o=0.
REQ-036 Signed overflow: op1=0x8000_0000, op2=1 -> diff=0x7FFF_FFFF, overflow_o=1; op1=0x7FFF_FFFF, op2=0xFFFF_FFFF -> diff=0x8000_0000, overflow_o=1, borrow_o=1.
REQ-037 Cross-slice carry: op1=0x0100_0000, op2=0x0000_0001 -> diff=0x00FF_FFFF; confirms the carry chain through all 4 stages.
REQ-038 Backpressure: stream 8 back-to-back inputs with ready_i low for cycles 5-7 -> ready_o is low during the stall, no result is lost or duplicated, order is preserved, and all results match a reference model.
REQ-039 Reset mid-stream: assert rst_ni low with 3 transactions in flight -> valid_o=0 at once and stays 0; after release, a new input yields exactly one correct result 4 cycles later.
